// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C request arbiter.
//   state_t            : arbiter FSM state encoding
//   MESSAGE_LENGTH_DEF : default byte width handed to the I2C master
//   TIMEOUT_DEF        : default watchdog limit in clk cycles
package i2c_pkg;
  localparam int MESSAGE_LENGTH_DEF = 8;
  localparam int TIMEOUT_DEF        = 1024;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } state_t;
endpackage

// File: rtl/i2c_arbiter_if.sv
// Bundle between the requesters / I2C master core and the arbiter.
//   req      : one request bit per requester
//   req_data : packed requester bytes, requester i at [i*MESSAGE_LENGTH +: MESSAGE_LENGTH]
//   ack      : one-hot completion pulse to the served requester
//   m_data   : byte presented to the I2C master
//   m_start  : one-cycle start pulse to the I2C master
//   m_done   : one-cycle end-of-transfer pulse from the I2C master
//   err      : watchdog abort pulse, coincident with ack
// Modports: master = arbiter side, slave = environment side.
interface i2c_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int MESSAGE_LENGTH = i2c_pkg::MESSAGE_LENGTH_DEF
);
  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ*MESSAGE_LENGTH-1:0] req_data;
  logic [NUM_REQ-1:0]                ack;
  logic [MESSAGE_LENGTH-1:0]         m_data;
  logic                              m_start;
  logic                              m_done;
  logic                              err;

  modport master (input req, req_data, m_done, output ack, m_data, m_start, err);
  modport slave  (output req, req_data, m_done, input ack, m_data, m_start, err);
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
//   req   : request vector
//   ptr   : index with highest priority this round
//   valid : at least one request present
//   index : first requesting index at or after ptr, wrapping to 0
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);
  assign valid = |req;

  // Walk from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin : pick
    int j;
    logic [IDX_W-1:0] cand;
    j     = 0;
    cand  = '0;
    index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IDX_W'(j);
      if (req[cand]) index = cand;
    end
  end
endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter granting one requester at a time access to an I2C master.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : i2c_arbiter_if.master (req/req_data/ack toward requesters,
//           m_data/m_start/m_done toward the I2C master, err)
// Optional feature: define I2C_ARB_TIMEOUT_EN to enable the WAIT_DONE watchdog;
// otherwise err is tied low and WAIT_DONE waits for m_done indefinitely.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int MESSAGE_LENGTH = MESSAGE_LENGTH_DEF,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT        = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  i2c_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  state_t                                state;
  logic [NUM_REQ-1:0]                    req_q;
  logic [IDX_W-1:0]                      ptr, owner, pick_idx;
  logic                                  pick_vld;
  logic [NUM_REQ-1:0]                    ack;
  logic [MESSAGE_LENGTH-1:0]             m_data;
  logic                                  m_start;
  logic [NUM_REQ-1:0][MESSAGE_LENGTH-1:0] data_arr;

  assign data_arr    = bus.req_data;
  assign bus.ack     = ack;
  assign bus.m_data  = m_data;
  assign bus.m_start = m_start;

  // Decisions are made on a registered copy of req, so every IDLE
  // decision sees a fresh sample and req->m_start is two cycles.
  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_q),
    .ptr   (ptr),
    .valid (pick_vld),
    .index (pick_idx)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0] wd;
  logic            err;
  assign bus.err = err;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > 0);
  assign bus.err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      req_q   <= '0;
      ptr     <= '0;
      owner   <= '0;
      ack     <= '0;
      m_start <= 1'b0;
      m_data  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      wd      <= '0;
      err     <= 1'b0;
`endif
    end else begin
      req_q   <= bus.req;
      ack     <= '0;
      m_start <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      err     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_vld) begin
            // m_data is only reloaded here, so it stays stable for the
            // whole transfer regardless of later req_data activity.
            owner   <= pick_idx;
            m_data  <= data_arr[pick_idx];
            m_start <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          state <= WAIT_DONE;
`ifdef I2C_ARB_TIMEOUT_EN
          wd    <= '0;
`endif
        end
        WAIT_DONE: begin
          if (bus.m_done) begin
            ack   <= NUM_REQ'(1) << owner;
            ptr   <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            state <= RELEASE;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (wd == WD_W'(TIMEOUT - 1)) begin
            ack   <= NUM_REQ'(1) << owner;
            err   <= 1'b1;
            ptr   <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            state <= RELEASE;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed self-checking bench for i2c_arbiter (4 requesters, 8-bit bytes).
module tb_i2c_arbiter;
  localparam int NR = 4;
  localparam int ML = 8;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif
  localparam logic [NR*ML-1:0] DATA = {8'h0F, 8'hF0, 8'h95, 8'h5F};

  logic clk, reset;
  int   checks, failures;

  i2c_arbiter_if #(.NUM_REQ(NR), .MESSAGE_LENGTH(ML)) bus ();

  i2c_arbiter #(.MESSAGE_LENGTH(ML), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset        = 1'b1;
    bus.req      = '0;
    bus.m_done   = 1'b0;
    bus.req_data = DATA;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for m_start; reports cycles waited and the byte shown.
  task automatic wait_start(output bit seen, output logic [ML-1:0] d, output int n);
    seen = 1'b0; d = '0; n = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (bus.m_start) begin seen = 1'b1; d = bus.m_data; end
    end
  endtask

  // Called in the LOAD cycle: pulses m_done in WAIT_DONE, returns ack/err seen.
  task automatic pulse_done(output logic [NR-1:0] a, output logic e);
    @(negedge clk);
    bus.m_done = 1'b1;
    @(negedge clk);
    bus.m_done = 1'b0;
    a = bus.ack;
    e = bus.err;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.req = '0; bus.m_done = 1'b0; bus.req_data = DATA;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0 || bus.m_start !== 1'b0 || bus.m_data !== 8'h00 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals: ack=%b m_start=%b m_data=%h err=%b, want 0000 0 00 0",
               bus.ack, bus.m_start, bus.m_data, bus.err);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit seen; logic [ML-1:0] d; int n; logic [NR-1:0] a; logic e;
    do_reset();
    bus.req = 4'b0001;
    wait_start(seen, d, n);
    checks++;
    if (!seen || n !== 2 || d !== 8'h5F) begin
      failures++;
      $display("FAIL single_start: seen=%0d lat=%0d m_data=%h, want 1 2 5f", seen, n, d);
    end
    pulse_done(a, e);
    bus.req = '0;
    checks++;
    if (a !== 4'b0001 || e !== 1'b0) begin
      failures++;
      $display("FAIL single_ack: ack=%b err=%b, want 0001 0", a, e);
    end
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0) begin
      failures++;
      $display("FAIL single_ack_width: ack=%b, want 0000", bus.ack);
    end
  endtask

  task automatic test_round_robin();
    bit seen; logic [ML-1:0] d; int n; logic [NR-1:0] a; logic e;
    logic [ML-1:0] exp_d [5];
    logic [NR-1:0] exp_a [5];
    exp_d = '{8'h5F, 8'h95, 8'hF0, 8'h0F, 8'h5F};
    exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_start(seen, d, n);
      checks++;
      if (!seen || n !== 2 || d !== exp_d[t]) begin
        failures++;
        $display("FAIL rr_data[%0d]: seen=%0d lat=%0d m_data=%h, want 1 2 %h", t, seen, n, d, exp_d[t]);
      end
      pulse_done(a, e);
      if (t == 4) bus.req = '0;
      checks++;
      if (a !== exp_a[t]) begin
        failures++;
        $display("FAIL rr_ack[%0d]: ack=%b, want %b", t, a, exp_a[t]);
      end
    end
  endtask

  task automatic test_wrap();
    bit seen; logic [ML-1:0] d; int n; logic [NR-1:0] a; logic e;
    do_reset();
    bus.req = 4'b0100;
    wait_start(seen, d, n);
    pulse_done(a, e);
    checks++;
    if (!seen || d !== 8'hF0 || a !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_pre: seen=%0d m_data=%h ack=%b, want 1 f0 0100", seen, d, a);
    end
    bus.req = 4'b0101;
    wait_start(seen, d, n);
    pulse_done(a, e);
    checks++;
    if (!seen || d !== 8'h5F || a !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_first: seen=%0d m_data=%h ack=%b, want 1 5f 0001", seen, d, a);
    end
    wait_start(seen, d, n);
    pulse_done(a, e);
    bus.req = '0;
    checks++;
    if (!seen || d !== 8'hF0 || a !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_second: seen=%0d m_data=%h ack=%b, want 1 f0 0100", seen, d, a);
    end
  endtask

  task automatic test_ignore_done();
    do_reset();
    bus.req    = 4'b0001;
    bus.m_done = 1'b1;                 // arrives while IDLE
    @(negedge clk);
    bus.m_done = 1'b0;
    checks++;
    if (bus.ack !== 4'b0 || bus.m_start !== 1'b0) begin
      failures++;
      $display("FAIL idle_done: ack=%b m_start=%b, want 0000 0", bus.ack, bus.m_start);
    end
    @(negedge clk);
    checks++;
    if (bus.m_start !== 1'b1) begin
      failures++;
      $display("FAIL load_reached: m_start=%b, want 1", bus.m_start);
    end
    bus.m_done = 1'b1;                 // arrives while LOAD
    @(negedge clk);
    bus.m_done = 1'b0;
    bus.req    = '0;                   // requester drops during WAIT_DONE
    bus.req_data[7:0] = 8'hAA;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0 || bus.m_data !== 8'h5F) begin
      failures++;
      $display("FAIL load_done: ack=%b m_data=%h, want 0000 5f", bus.ack, bus.m_data);
    end
    bus.m_done = 1'b1;
    @(negedge clk);
    bus.m_done = 1'b0;
    checks++;
    if (bus.ack !== 4'b0001 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL dropped_req_ack: ack=%b err=%b, want 0001 0", bus.ack, bus.err);
    end
    bus.req_data = DATA;
  endtask

  task automatic test_timeout();
    bit seen; logic [ML-1:0] d; int n;
    int cyc; bit got; logic e_at; logic [NR-1:0] a_at; bit early_err;
    do_reset();
    bus.req = 4'b0010;
    wait_start(seen, d, n);
    bus.req = '0;
`ifdef I2C_ARB_TIMEOUT_EN
    got = 1'b0; cyc = 0; e_at = 1'b0; a_at = '0; early_err = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != 0) begin got = 1'b1; a_at = bus.ack; e_at = bus.err; end
      else if (bus.err) early_err = 1'b1;
    end
    // WAIT_DONE is entered one edge after the LOAD sample point.
    checks++;
    if (!seen || !got || cyc !== 17 || a_at !== 4'b0010 || e_at !== 1'b1 || early_err) begin
      failures++;
      $display("FAIL timeout: seen=%0d got=%0d cyc=%0d ack=%b err=%b early_err=%0d, want 1 1 17 0010 1 0",
               seen, got, cyc, a_at, e_at, early_err);
    end
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_width: ack=%b err=%b, want 0000 0", bus.ack, bus.err);
    end
`else
    got = 1'b0; cyc = 0; e_at = 1'b0; a_at = '0; early_err = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.ack != 0) got = 1'b1;
      if (bus.err) early_err = 1'b1;
    end
    checks++;
    if (!seen || got || early_err) begin
      failures++;
      $display("FAIL no_timeout: seen=%0d ack_seen=%0d err_seen=%0d, want 1 0 0", seen, got, early_err);
    end
    bus.m_done = 1'b1;
    @(negedge clk);
    bus.m_done = 1'b0;
    a_at = bus.ack;
    checks++;
    if (a_at !== 4'b0010) begin
      failures++;
      $display("FAIL late_done_ack: ack=%b, want 0010", a_at);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit seen; logic [ML-1:0] d; int n; bit got;
    do_reset();
    bus.req = 4'b1000;
    wait_start(seen, d, n);
    @(negedge clk);                    // now in WAIT_DONE
    bus.req = '0;
    reset   = 1'b1;
    @(negedge clk);
    checks++;
    if (!seen || d !== 8'h0F || bus.ack !== 4'b0 || bus.m_start !== 1'b0 ||
        bus.m_data !== 8'h00 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: seen=%0d d=%h ack=%b m_start=%b m_data=%h err=%b, want 1 0f 0000 0 00 0",
               seen, d, bus.ack, bus.m_start, bus.m_data, bus.err);
    end
    reset      = 1'b0;
    bus.m_done = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.m_done = 1'b0;
      if (bus.ack != 0 || bus.err || bus.m_start) got = 1'b1;
    end
    checks++;
    if (got) begin
      failures++;
      $display("FAIL reset_mid_quiet: activity=%0d, want 0", got);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_ignore_done();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter MESSAGE_LENGTH, default 8, SHALL set the byte width passed to the I2C master.
REQ-002 Parameter NUM_REQ, default 4, range 2..8, SHALL set the number of requesters.
REQ-003 Parameter TIMEOUT, default 1024, SHALL set the watchdog limit in clk cycles.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  SHALL be synchronous and active-high.
REQ-006 req  in  NUM_REQ  SHALL carry one transfer request bit per requester.
REQ-007 req_data  in  NUM_REQ*MESSAGE_LENGTH  SHALL carry each requester's byte; requester i uses slice [i*MESSAGE_LENGTH +: MESSAGE_LENGTH].
REQ-008 ack  out  NUM_REQ  SHALL carry a one-hot, one-cycle completion pulse to the served requester.
REQ-009 m_data  out  MESSAGE_LENGTH  SHALL drive the byte to the master's data port.
REQ-010 m_start  out  1  SHALL carry a one-cycle pulse telling the master to begin a transfer.
REQ-011 m_done  in  1  SHALL carry the master's one-cycle end-of-transfer pulse.
REQ-012 err  out  1  SHALL pulse for one cycle, coincident with ack, on watchdog abort.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, WAIT_DONE and RELEASE.
REQ-014 In IDLE with req != 0, the block SHALL pick a winner round-robin starting at pointer ptr, latch the winner's index and req_data into m_data, and go to LOAD in the next cycle.
REQ-015 In LOAD, m_start SHALL be 1 for exactly one cycle; the next state SHALL be WAIT_DONE.
REQ-016 m_done SHALL be ignored in every state except WAIT_DONE.
REQ-017 In WAIT_DONE, m_done=1 SHALL cause a move to RELEASE.
REQ-018 In RELEASE, ack[owner] SHALL be 1 for one cycle, ptr SHALL become (owner+1) mod NUM_REQ, and the next state SHALL be IDLE.
REQ-019 Latency from req rising in IDLE to m_start SHALL be 2 cycles, and from m_done to ack SHALL be 1 cycle.
REQ-020 m_data SHALL hold the latched byte, unchanged, from LOAD until the block next leaves IDLE.
REQ-021 req or req_data changing after the latch SHALL NOT affect the current transfer; ack SHALL still be issued to the owner.
REQ-022 With all requesters asserting continuously, each SHALL be served once per NUM_REQ transfers, in index order, wrapping from NUM_REQ-1 to 0.
REQ-023 Each new IDLE decision SHALL use a freshly sampled req.
REQ-024 At most one transfer SHALL be outstanding at any time.

Reset
REQ-025 Reset SHALL set: state=IDLE, ptr=0, ack=0, m_start=0, m_data=0, err=0, watchdog=0.
REQ-026 Reset asserted mid-transfer SHALL abandon the transfer with no ack or err issued; the outputs SHALL take their reset values on the next edge.

Configuration
REQ-027 With I2C_ARB_TIMEOUT_EN defined, a watchdog counter SHALL clear on entering WAIT_DONE and count each cycle in WAIT_DONE.
REQ-028 With I2C_ARB_TIMEOUT_EN defined, reaching TIMEOUT-1 without m_done SHALL force RELEASE with err=1 alongside ack.
REQ-029 With I2C_ARB_TIMEOUT_EN undefined, the watchdog counter SHALL be absent, err SHALL be tied to 0, and WAIT_DONE SHALL wait indefinitely.

Structure
REQ-030 A shared package i2c_pkg SHALL hold the FSM state enumeration, the MESSAGE_LENGTH default and the TIMEOUT default.
REQ-031 Round-robin selection SHALL live in sub-module rr_picker (inputs req and ptr; outputs valid and index), which is purely combinational.

Verification
REQ-032 Reset, then req=4'b0001 with data0=8'b01011111: m_start SHALL pulse 2 cycles later with m_data=0x5F, and m_done SHALL produce ack=4'b0001 one cycle later.
REQ-033 req=4'b1111 held, data 0x5F, 0x95, 0xF0, 0x0F: m_data order SHALL be 0x5F, 0x95, 0xF0, 0x0F, then 0x5F again.
REQ-034 After serving requester 2, with req=4'b0101: requester 0 SHALL win (wrap); requester 2 SHALL be served next.
REQ-035 m_done pulsed during LOAD and IDLE SHALL produce no ack; req dropped during WAIT_DONE SHALL still produce ack on m_done.
REQ-036 With I2C_ARB_TIMEOUT_EN defined, TIMEOUT=16 and m_done never asserted: ack and err SHALL both pulse 16 cycles after WAIT_DONE entry; without the macro, there SHALL be no ack after 2000 cycles.
REQ-037 Reset asserted in WAIT_DONE: there SHALL be no ack, and outputs SHALL be at their reset values next cycle.
